imem_program_loader: RTL and testbench

//  Writer side of the instruction-memory interface: the core's fetch unit only reads IMEM, and this block fills it.
//  It receives a byte stream over a valid/ready handshake, packs bytes into 19-bit instruction words and writes them to IMEM.
//  It holds the core in reset via cpu_hold until the load completes.

---
 rtl/imem_program_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream frame loader that fills IMEM and holds the core in reset until done
module imem_program_loader #(
    parameter int INSTR_W = 19,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    localparam int           CNT_W   = $clog2(DEPTH + 1);
    localparam int           HI_W    = INSTR_W - 16;
    localparam logic [7:0]   DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   n_cnt;
    logic [ADDR_W-1:0]  word_idx;
    logic [1:0]         byte_idx;
    logic [7:0]         checksum;
    logic [15:0]        word_lo;

    logic xfer;
    logic start_acc;
    logic count_bad;
    logic pad_bad;
    logic last_word;

    assign xfer      = rx_valid & rx_ready;
    assign start_acc = start & ((state == S_IDLE) | (state == S_ERROR));
    assign count_bad = (rx_data == 8'd0) | (rx_data > DEPTH_B);
    assign pad_bad   = (rx_data[7:HI_W] != '0);
    assign last_word = (CNT_W'(word_idx) == (n_cnt - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COUNT;
            S_COUNT:   if (xfer) state_nxt = count_bad ? S_ERROR : S_PAYLOAD;
            S_PAYLOAD: begin
                if (xfer && byte_idx == 2'd2) begin
                    state_nxt = pad_bad ? S_ERROR : S_WRITE;
                end
            end
            S_WRITE:   state_nxt = last_word ? S_CHECK : S_PAYLOAD;
            S_CHECK:   if (xfer) state_nxt = (rx_data == checksum) ? S_DONE : S_ERROR;
            S_DONE:    state_nxt = S_IDLE;
            S_ERROR:   if (start) state_nxt = S_COUNT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        cpu_hold = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_COUNT, S_PAYLOAD, S_CHECK: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                imem_we  = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERROR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Address/data are latched on the third byte so they are stable for the WRITE cycle and held after it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_cnt      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            word_lo    <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err_code   <= 2'b00;
        end else begin
            if (start_acc) begin
                checksum <= '0;
                word_idx <= '0;
                byte_idx <= '0;
                err_code <= 2'b00;
            end
            case (state)
                S_COUNT: begin
                    if (xfer) begin
                        n_cnt    <= rx_data[CNT_W-1:0];
                        checksum <= checksum ^ rx_data;
                        if (count_bad) err_code <= 2'b01;
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        checksum <= checksum ^ rx_data;
                        case (byte_idx)
                            2'd0: begin
                                word_lo[7:0] <= rx_data;
                                byte_idx     <= 2'd1;
                            end
                            2'd1: begin
                                word_lo[15:8] <= rx_data;
                                byte_idx      <= 2'd2;
                            end
                            default: begin
                                if (pad_bad) begin
                                    err_code <= 2'b10;
                                end else begin
                                    imem_addr  <= word_idx;
                                    imem_wdata <= {rx_data[HI_W-1:0], word_lo};
                                end
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + ADDR_W'(1);
                        byte_idx <= 2'd0;
                    end
                end
                S_CHECK: begin
                    if (xfer && rx_data != checksum) err_code <= 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [18:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    int          wr_cnt = 0;
    logic [3:0]  wr_addr [256];
    logic [18:0] wr_data [256];
    logic [18:0] mem [16];
    int          base;

    always #5 clk = ~clk;

    imem_program_loader #(.INSTR_W(19), .ADDR_W(4), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always @(posedge clk) begin
        if (imem_we) begin
            wr_addr[wr_cnt[7:0]] <= imem_addr;
            wr_data[wr_cnt[7:0]] <= imem_wdata;
            mem[imem_addr]       <= imem_wdata;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) step();
        send_byte(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b1;
        step();

        // T1: single word 19'h00013, checksum 01^13 = 12
        base = wr_cnt;
        pulse_start();
        check("t1_hold", 32'(cpu_hold), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t1_we", 32'(imem_we), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'd0);
        check("t1_wdata", 32'(imem_wdata), 32'h00013);
        check("t1_ready_in_write", 32'(rx_ready), 32'd0);
        send_byte(8'h12);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold_fall", 32'(cpu_hold), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("t1_addr_hold", 32'(imem_addr), 32'd0);
        check("t1_wdata_hold", 32'(imem_wdata), 32'h00013);

        // T2: 16 words 19'h40000+i; checksum 10 ^ (0^..^15) ^ 0 = 10
        base = wr_cnt;
        pulse_start();
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
            send_byte(8'h04);
        end
        send_byte(8'h10);
        check("t2_done", 32'(done), 32'd1);
        check("t2_wr_cnt", 32'(wr_cnt - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
            check($sformatf("t2_data%0d", i), 32'(wr_data[base + i]), 32'h40000 + 32'(i));
        end
        step();

        // T3: bad counts 00 and 11
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00);
        check("t3a_error", 32'(error), 32'd1);
        check("t3a_code", 32'(err_code), 32'd1);
        check("t3a_hold", 32'(cpu_hold), 32'd1);
        check("t3a_busy", 32'(busy), 32'd0);
        pulse_start();
        check("t3b_error_clr", 32'(error), 32'd0);
        check("t3b_code_clr", 32'(err_code), 32'd0);
        send_byte(8'h11);
        check("t3b_error", 32'(error), 32'd1);
        check("t3b_code", 32'(err_code), 32'd1);
        check("t3b_hold", 32'(cpu_hold), 32'd1);
        repeat (3) step();
        check("t3_hold_sticky", 32'(cpu_hold), 32'd1);
        check("t3_wr_cnt", 32'(wr_cnt - base), 32'd0);

        // T4: second word has pad bits set in third byte
        base = wr_cnt;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h05);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h08);
        check("t4_error", 32'(error), 32'd1);
        check("t4_code", 32'(err_code), 32'd2);
        check("t4_we", 32'(imem_we), 32'd0);
        step();
        check("t4_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("t4_mem0", 32'(mem[0]), 32'h51234);
        check("t4_mem1", 32'(mem[1]), 32'h40001);

        // T5: bad checksum (13 vs 12), then recovery with word 7FFFF, checksum 06
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13);
        check("t5_error", 32'(error), 32'd1);
        check("t5_code", 32'(err_code), 32'd3);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        base = wr_cnt;
        pulse_start();
        check("t5_error_clr", 32'(error), 32'd0);
        send_byte(8'h01);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h07);
        send_byte(8'h06);
        check("t5_done", 32'(done), 32'd1);
        check("t5_error_low", 32'(error), 32'd0);
        check("t5_hold_low", 32'(cpu_hold), 32'd0);
        step();
        check("t5_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("t5_mem0", 32'(mem[0]), 32'h7FFFF);

        // T6a: gaps and stray start pulses; words 00001, 00102, 30203; checksum 03
        base = wr_cnt;
        pulse_start();
        send_gap(8'h03);
        send_gap(8'h01); send_gap(8'h00); send_gap(8'h00);
        send_gap(8'h02);
        pulse_start();
        check("t6_busy_start", 32'(busy), 32'd1);
        send_gap(8'h01); send_gap(8'h00);
        send_gap(8'h03);
        pulse_start();
        send_gap(8'h02); send_gap(8'h03);
        send_gap(8'h03);
        check("t6_done", 32'(done), 32'd1);
        step();
        check("t6_wr_cnt", 32'(wr_cnt - base), 32'd3);
        check("t6_a0", 32'(wr_addr[base]), 32'd0);
        check("t6_d0", 32'(wr_data[base]), 32'h00001);
        check("t6_a1", 32'(wr_addr[base + 1]), 32'd1);
        check("t6_d1", 32'(wr_data[base + 1]), 32'h00102);
        check("t6_a2", 32'(wr_addr[base + 2]), 32'd2);
        check("t6_d2", 32'(wr_data[base + 2]), 32'h30203);

        // T6b: reset mid-PAYLOAD, then word 2ABCD with checksum 65
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        reset = 1'b1;
        step();
        check("t6_mem2_kept", 32'(mem[2]), 32'h30203);
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h02);
        check("t6b_we", 32'(imem_we), 32'd1);
        check("t6b_wdata", 32'(imem_wdata), 32'h2ABCD);
        send_byte(8'h65);
        check("t6b_done", 32'(done), 32'd1);
        step();
        check("t6b_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("t6b_mem0", 32'(mem[0]), 32'h2ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
